mem_access_unit: RTL and testbench

Memory-stage load/store unit that consumes the EX/MEM pipeline register (ALU result as address, forwarded store data, funct3, control bits) and drives the data-memory request/ready interface. It also generates byte enables, performs load extraction and sign/zero extension, and stalls the upstream pipeline while an access is outstanding. Results are presented registered to the MEM/WB pipeline register, and a fault pulse is raised for misaligned or illegal accesses and bus timeouts.

---
 rtl/mem_access_unit_if.sv | 20 ++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory request/ready bus between the load/store unit and memory
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit: byte enables, load extension, stall and fault
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       store_data_in,
  input  logic [4:0]        rd_in,
  input  logic [2:0]        funct3_in,
  input  logic              RegWrite_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              MemToReg_in,
  output logic              stall_out,
  mem_access_unit_if.master dmem,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_RegWrite,
  output logic              wb_MemToReg,
  output logic [31:0]       wb_alu_result,
  output logic [31:0]       wb_load_data,
  output logic              fault_out
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        mem_op, legal_f3, aligned, go, timeout_hit;
  logic [1:0]  off;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;
  logic [31:0] load_val;

  assign off         = alu_result_in[1:0];
  assign mem_op      = ex_valid & (MemRead_in | MemWrite_in);
  assign go          = mem_op & legal_f3 & aligned;
  assign timeout_hit = (cnt == CNT_LAST);

  assign dmem.dmem_req   = (state == ACCESS);
  assign dmem.dmem_we    = req_we;
  assign dmem.dmem_addr  = req_addr;
  assign dmem.dmem_wdata = req_wdata;
  assign dmem.dmem_be    = req_be;

  always_comb begin
    legal_f3   = 1'b0;
    aligned    = 1'b1;
    be_next    = 4'b1111;
    wdata_next = store_data_in;
    case (funct3_in)
      3'b000, 3'b100: begin
        legal_f3   = MemRead_in | (funct3_in == 3'b000);
        be_next    = 4'b0001 << off;
        wdata_next = {4{store_data_in[7:0]}};
      end
      3'b001, 3'b101: begin
        legal_f3   = MemRead_in | (funct3_in == 3'b001);
        aligned    = ~off[0];
        be_next    = 4'b0011 << {off[1], 1'b0};
        wdata_next = {2{store_data_in[15:0]}};
      end
      3'b010: begin
        legal_f3 = 1'b1;
        aligned  = (off == 2'b00);
      end
      default: legal_f3 = 1'b0;
    endcase
  end

  // Upstream holds EX/MEM while stalled, so the live funct3/offset still describe the access.
  always_comb begin
    lbyte    = dmem.dmem_rdata[{off, 3'b000} +: 8];
    lhalf    = dmem.dmem_rdata[{off[1], 4'b0000} +: 16];
    load_val = dmem.dmem_rdata;
    case (funct3_in)
      3'b000:  load_val = {{24{lbyte[7]}}, lbyte};
      3'b100:  load_val = {24'd0, lbyte};
      3'b001:  load_val = {{16{lhalf[15]}}, lhalf};
      3'b101:  load_val = {16'd0, lhalf};
      default: load_val = dmem.dmem_rdata;
    endcase
    if (MemWrite_in) load_val = 32'd0;
  end

  always_comb begin
    stall_out = 1'b0;
    if (state == IDLE) stall_out = go;
    else               stall_out = ~dmem.dmem_ready & ~timeout_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      req_we        <= 1'b0;
      req_addr      <= 32'd0;
      req_wdata     <= 32'd0;
      req_be        <= 4'd0;
      wb_valid      <= 1'b0;
      wb_rd         <= 5'd0;
      wb_RegWrite   <= 1'b0;
      wb_MemToReg   <= 1'b0;
      wb_alu_result <= 32'd0;
      wb_load_data  <= 32'd0;
      fault_out     <= 1'b0;
    end else begin
      fault_out <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state     <= ACCESS;
            cnt       <= '0;
            req_we    <= MemWrite_in;
            req_addr  <= {alu_result_in[31:2], 2'b00};
            req_wdata <= wdata_next;
            req_be    <= be_next;
            wb_valid  <= 1'b0;
          end else begin
            // Non-memory ops pass straight through; a rejected memory op retires as a fault.
            wb_valid      <= ex_valid;
            wb_rd         <= rd_in;
            wb_RegWrite   <= RegWrite_in & ~mem_op;
            wb_MemToReg   <= MemToReg_in;
            wb_alu_result <= alu_result_in;
            wb_load_data  <= 32'd0;
            fault_out     <= mem_op;
          end
        end
        ACCESS: begin
          if (dmem.dmem_ready || timeout_hit) begin
            state         <= IDLE;
            wb_valid      <= 1'b1;
            wb_rd         <= rd_in;
            wb_MemToReg   <= MemToReg_in;
            wb_alu_result <= alu_result_in;
            wb_RegWrite   <= RegWrite_in & dmem.dmem_ready;
            wb_load_data  <= dmem.dmem_ready ? load_val : 32'd0;
            fault_out     <= ~dmem.dmem_ready;
          end else begin
            cnt      <= cnt + 1'b1;
            wb_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed and randomized bench for mem_access_unit with a word-memory model
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] alu_result_in, store_data_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic        RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in;
  logic        stall_out;
  logic        wb_valid, wb_RegWrite, wb_MemToReg, fault_out;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu_result, wb_load_data;

  mem_access_unit_if dmem();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .rd_in(rd_in), .funct3_in(funct3_in),
    .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in),
    .MemWrite_in(MemWrite_in), .MemToReg_in(MemToReg_in),
    .stall_out(stall_out), .dmem(dmem),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite),
    .wb_MemToReg(wb_MemToReg), .wb_alu_result(wb_alu_result),
    .wb_load_data(wb_load_data), .fault_out(fault_out)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int unsigned mem [int unsigned];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned rd_word(input int unsigned a);
    return mem.exists(a >> 2) ? mem[a >> 2] : 0;
  endfunction

  // kind: 0 = ALU op, 1 = load, 2 = store; lat = ready arrives after this many waiting ACCESS cycles
  task automatic run_op(input bit v, input int kind, input logic [2:0] f3, input int unsigned addr,
                        input int unsigned sd, input logic [4:0] rd, input int lat, input string tag);
    bit memop, legal, flt, rq, st;
    int unsigned size, eaddr, off, w, b, h, exp_be, exp_wd, exp_ld;
    int exp_cyc, exp_req, cyc, reqc, stalls;
    memop = v && (kind != 0);
    if (kind == 1) legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    else           legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
    size  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    legal = legal && (addr % size == 0);
    eaddr = addr - addr % 4;
    off   = addr % 4;
    w = rd_word(eaddr);
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0: exp_ld = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4: exp_ld = b;
      3'd1: exp_ld = (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5: exp_ld = h;
      default: exp_ld = w;
    endcase
    if (size == 1)      begin exp_be = 1 << off;          exp_wd = (sd % 256) * 32'h0101_0101; end
    else if (size == 2) begin exp_be = 3 << (2*(off/2));  exp_wd = (sd % 65536) * 32'h0001_0001; end
    else                begin exp_be = 15;                exp_wd = sd; end
    flt     = memop && (!legal || lat >= TO);
    exp_cyc = (!memop || !legal) ? 1 : (lat >= TO) ? TO + 1 : lat + 2;
    exp_req = (!memop || !legal) ? 0 : (lat >= TO) ? TO : lat + 1;

    ex_valid = v; alu_result_in = addr; store_data_in = sd; rd_in = rd; funct3_in = f3;
    MemRead_in = (kind == 1); MemWrite_in = (kind == 2);
    RegWrite_in = (kind != 2); MemToReg_in = (kind == 1);
    chk({tag, "_req_idle"}, dmem.dmem_req, 0);

    cyc = 0; reqc = 0; stalls = 0;
    do begin
      rq = dmem.dmem_req;
      dmem.dmem_ready = rq && (reqc == lat);
      dmem.dmem_rdata = rd_word(eaddr);
      #1;
      if (rq) begin
        chk({tag, "_addr"}, dmem.dmem_addr, eaddr);
        chk({tag, "_be"}, dmem.dmem_be, exp_be);
        chk({tag, "_we"}, dmem.dmem_we, kind == 2);
        if (kind == 2) chk({tag, "_wdata"}, dmem.dmem_wdata, exp_wd);
      end
      st = stall_out;
      if (st) stalls++;
      @(posedge clk); #1;
      cyc++;
      if (rq) reqc++;
    end while (st && cyc < 40);
    dmem.dmem_ready = 1'b0;

    chk({tag, "_latency"}, cyc, exp_cyc);
    chk({tag, "_req_cycles"}, reqc, exp_req);
    chk({tag, "_stalls"}, stalls, exp_cyc - 1);
    chk({tag, "_wb_valid"}, wb_valid, v);
    chk({tag, "_wb_rd"}, wb_rd, rd);
    chk({tag, "_wb_alu"}, wb_alu_result, addr);
    chk({tag, "_wb_regwrite"}, wb_RegWrite, flt ? 0 : (kind != 2));
    chk({tag, "_wb_memtoreg"}, wb_MemToReg, kind == 1);
    chk({tag, "_fault"}, fault_out, flt);
    if (memop && !flt) chk({tag, "_load_data"}, wb_load_data, (kind == 1) ? exp_ld : 0);
    if (memop && !flt && kind == 2)
      for (int i = 0; i < 4; i++)
        if (exp_be[i]) mem[eaddr >> 2] = (rd_word(eaddr) & ~(32'hFF << (8*i))) | (exp_wd & (32'hFF << (8*i)));
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] st_f3 [3];
    int kind;
    logic [2:0] f3;
    int unsigned a;
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    st_f3 = '{3'd0, 3'd1, 3'd2};
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    rst_n = 1'b0; ex_valid = 0; alu_result_in = 0; store_data_in = 0; rd_in = 0; funct3_in = 0;
    RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0; MemToReg_in = 0;
    dmem.dmem_ready = 0; dmem.dmem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", dmem.dmem_req, 0);
    chk("rst_we", dmem.dmem_we, 0);
    chk("rst_addr", dmem.dmem_addr, 0);
    chk("rst_wdata", dmem.dmem_wdata, 0);
    chk("rst_be", dmem.dmem_be, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_regwrite", wb_RegWrite, 0);
    chk("rst_wb_alu", wb_alu_result, 0);
    chk("rst_wb_load", wb_load_data, 0);
    chk("rst_fault", fault_out, 0);
    rst_n = 1'b1;

    run_op(1, 0, 3'd0, 32'h1234, 0, 5'd5, 0, "add");
    mem[32'h100 >> 2] = 32'h80FF_0000;
    run_op(1, 1, 3'd0, 32'h103, 0, 5'd7, 2, "lb");
    chk("lb_value", wb_load_data, 32'hFFFF_FF80);
    run_op(1, 2, 3'd1, 32'h202, 32'hABCD_1234, 5'd0, 0, "sh");
    chk("sh_memory", rd_word(32'h200) >> 16, 32'h1234);
    run_op(1, 1, 3'd2, 32'h006, 0, 5'd9, 0, "lw_misaligned");
    run_op(1, 1, 3'd2, 32'h010, 0, 5'd3, 100, "lw_timeout");
    run_op(0, 0, 3'd0, 32'h55, 0, 5'd1, 0, "bubble");

    ex_valid = 1; alu_result_in = 32'h40; funct3_in = 3'd2; rd_in = 5'd4;
    MemRead_in = 1; MemWrite_in = 0; RegWrite_in = 1; MemToReg_in = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_req_before_reset", dmem.dmem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_req", dmem.dmem_req, 0);
    chk("mid_reset_wb_valid", wb_valid, 0);
    ex_valid = 0; MemRead_in = 0;
    @(posedge clk); #1;
    chk("mid_reset_no_wb", wb_valid, 0);
    rst_n = 1'b1;
    mem[32'h100 >> 2] = 32'h0000_9900;
    run_op(1, 1, 3'd5 - 3'd1, 32'h101, 0, 5'd6, 1, "lbu");
    chk("lbu_value", wb_load_data, 32'h0000_0099);

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 9) < 7) f3 = (kind == 2) ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      a = $urandom_range(0, 1023);
      if ($urandom_range(0, 9) < 7) a = (f3[1:0] == 2'b00) ? a : (f3[1:0] == 2'b01) ? a & ~32'd1 : a & ~32'd3;
      run_op($urandom_range(0, 7) != 0, kind, f3, a, $urandom, 5'($urandom), $urandom_range(0, 5), "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
